// File: rtl/seg_scan_drv_pkg.sv
// Shared constants for the clock display path: segment codes, digit positions
// and the packed BCD time layout {hou_h,hou_l,min_h,min_l,sec_h,sec_l}.
package seg_pkg;

  localparam int TIME_W = 20;

  localparam int SEC_L_LSB = 0;
  localparam int SEC_H_LSB = 4;
  localparam int MIN_L_LSB = 7;
  localparam int MIN_H_LSB = 11;
  localparam int HOU_L_LSB = 14;
  localparam int HOU_H_LSB = 18;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_ERR   = 7'h79;

  localparam logic [2:0] POS_SEC_L  = 3'd0;
  localparam logic [2:0] POS_SEC_H  = 3'd1;
  localparam logic [2:0] POS_DASH_S = 3'd2;
  localparam logic [2:0] POS_MIN_L  = 3'd3;
  localparam logic [2:0] POS_MIN_H  = 3'd4;
  localparam logic [2:0] POS_DASH_M = 3'd5;
  localparam logic [2:0] POS_HOU_L  = 3'd6;
  localparam logic [2:0] POS_HOU_H  = 3'd7;

  function automatic logic [3:0] pos_digit(input logic [TIME_W-1:0] t, input logic [2:0] pos);
    logic [3:0] d;
    case (pos)
      POS_SEC_L: d = t[SEC_L_LSB +: 4];
      POS_SEC_H: d = {1'b0, t[SEC_H_LSB +: 3]};
      POS_MIN_L: d = t[MIN_L_LSB +: 4];
      POS_MIN_H: d = {1'b0, t[MIN_H_LSB +: 3]};
      POS_HOU_L: d = t[HOU_L_LSB +: 4];
      POS_HOU_H: d = {2'b00, t[HOU_H_LSB +: 2]};
      default:   d = 4'd0;
    endcase
    return d;
  endfunction

  // Selects 6 and 7 land on a dash slot; callers gate them out before use.
  function automatic logic [2:0] edit_pos(input logic [2:0] sel);
    logic [2:0] p;
    case (sel)
      3'd0:    p = POS_SEC_L;
      3'd1:    p = POS_SEC_H;
      3'd2:    p = POS_MIN_L;
      3'd3:    p = POS_MIN_H;
      3'd4:    p = POS_HOU_L;
      3'd5:    p = POS_HOU_H;
      default: p = POS_DASH_S;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_drv_seg7_decode.sv
// BCD digit to seven-segment pattern {g,f,e,d,c,b,a}, active-high.
// Blank overrides dash, dash overrides the digit value.
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       is_dash_i,
  input  logic       is_blank_i,
  output logic [6:0] seg_o
);

  // Segment lookup with override
  always_comb begin
    seg_o = SEG_ERR;
    if (is_blank_i) begin
      seg_o = SEG_BLANK;
    end else if (is_dash_i) begin
      seg_o = SEG_DASH;
    end else begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_ERR;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_drv.sv
// Two-group multiplexed seven-segment driver showing HH-MM-SS, with per-slot
// ghost blanking, a frame-latched time shadow and a blinking edit digit.
module seg_scan_drv
  import seg_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int GUARD_CYC = 16,
  parameter int BLINK_HZ  = 2
) (
  input  logic              clk_sys,
  input  logic              rstn,
  input  logic [TIME_W-1:0] time_data,
  input  logic              blink_en,
  input  logic [2:0]        blink_bit,
  output logic [6:0]        led0,
  output logic [6:0]        led1,
  output logic [3:0]        led_mux0,
  output logic [3:0]        led_mux1,
  output logic              dp0,
  output logic              dp1
);

  localparam int SCAN_DIV   = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0]  GUARD_LIM  = SCAN_W'(GUARD_CYC);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  logic [SCAN_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [TIME_W-1:0]  shadow_q, shadow_d;
  logic               first_q;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_on_q, blink_on_d;
  logic               blink_en_q;
  logic [2:0]         blink_bit_q;
  logic [6:0]         led0_q, led1_q, led0_d, led1_d;
  logic [3:0]         mux_q, mux_d;
  logic               dp0_q, dp1_q, dp0_d, dp1_d;

  logic [TIME_W-1:0]  data_s;
  logic               restart_s, blink_on_s, edit_ok_s, guard_s;
  logic [2:0]         edit_pos_s, pos0_s, pos1_s;
  logic               hit0_s, hit1_s, blank0_s, blank1_s, dash0_s, dash1_s;
  logic [3:0]         dig0_s, dig1_s;

  // Slot timer and frame-boundary shadow capture
  always_comb begin
    idx_d    = idx_q;
    shadow_d = shadow_q;
    if (slot_cnt_q == SCAN_LAST) begin
      slot_cnt_d = '0;
      idx_d      = idx_q - 2'd1;
      if (idx_q == 2'd0) begin
        shadow_d = time_data;
      end else begin
        shadow_d = shadow_q;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + SCAN_W'(1);
    end
    if (first_q) begin
      shadow_d = time_data;
    end else begin
      shadow_d = shadow_d;
    end
  end

  // A new edit target or a fresh enable restarts the blink in its visible phase.
  always_comb begin
    restart_s = blink_en && (!blink_en_q || (blink_bit != blink_bit_q));
    if (restart_s) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      blink_on_d  = !blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      blink_on_d  = blink_on_q;
    end
    blink_on_s = restart_s || blink_on_q;
  end

  // Per-slot digit selection, blink/dp masks and guard gating
  always_comb begin
    data_s     = first_q ? time_data : shadow_q;
    pos0_s     = {1'b0, idx_q};
    pos1_s     = {1'b1, idx_q};
    edit_ok_s  = blink_en && (blink_bit <= 3'd5);
    edit_pos_s = edit_pos(blink_bit);
    hit0_s     = edit_ok_s && (edit_pos_s == pos0_s);
    hit1_s     = edit_ok_s && (edit_pos_s == pos1_s);
    blank0_s   = hit0_s && !blink_on_s;
    blank1_s   = hit1_s && !blink_on_s;
    dash0_s    = (pos0_s == POS_DASH_S);
    dash1_s    = (pos1_s == POS_DASH_M);
    dig0_s     = pos_digit(data_s, pos0_s);
    dig1_s     = pos_digit(data_s, pos1_s);
    guard_s    = (slot_cnt_q < GUARD_LIM);
    if (guard_s) begin
      mux_d = 4'b0000;
    end else begin
      mux_d = 4'b0001 << idx_q;
    end
    dp0_d = !guard_s && hit0_s;
    dp1_d = !guard_s && hit1_s;
  end

  seg7_decode u_dec0 (
    .bcd_i      (dig0_s),
    .is_dash_i  (dash0_s),
    .is_blank_i (blank0_s),
    .seg_o      (led0_d)
  );

  seg7_decode u_dec1 (
    .bcd_i      (dig1_s),
    .is_dash_i  (dash1_s),
    .is_blank_i (blank1_s),
    .seg_o      (led1_d)
  );

  // Scan state registers
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      slot_cnt_q <= '0;
      idx_q      <= 2'd3;
      shadow_q   <= '0;
      first_q    <= 1'b1;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      first_q    <= 1'b0;
    end
  end

  // Blink state registers
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      blink_en_q  <= 1'b0;
      blink_bit_q <= 3'd0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      blink_en_q  <= blink_en;
      blink_bit_q <= blink_bit;
    end
  end

  // Output registers
  always_ff @(posedge clk_sys or negedge rstn) begin
    if (!rstn) begin
      led0_q <= 7'h00;
      led1_q <= 7'h00;
      mux_q  <= 4'b0000;
      dp0_q  <= 1'b0;
      dp1_q  <= 1'b0;
    end else begin
      led0_q <= led0_d;
      led1_q <= led1_d;
      mux_q  <= mux_d;
      dp0_q  <= dp0_d;
      dp1_q  <= dp1_d;
    end
  end

  assign led0     = led0_q;
  assign led1     = led1_q;
  assign led_mux0 = mux_q;
  assign led_mux1 = mux_q;
  assign dp0      = dp0_q;
  assign dp1      = dp1_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Directed, table-driven bench for seg_scan_drv with a reduced clock
// (SCAN_DIV=10, GUARD=2, BLINK_HALF=10); expected values are hand-derived.
module tb_seg_scan_drv;

  logic        clk_sys = 1'b0;
  logic        rstn;
  logic [19:0] time_data;
  logic        blink_en;
  logic [2:0]  blink_bit;
  logic [6:0]  led0, led1;
  logic [3:0]  led_mux0, led_mux1;
  logic        dp0, dp1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_sys = ~clk_sys;

  seg_scan_drv #(
    .CLK_HZ    (1000),
    .SCAN_HZ   (100),
    .GUARD_CYC (2),
    .BLINK_HZ  (50)
  ) dut (
    .clk_sys   (clk_sys),
    .rstn      (rstn),
    .time_data (time_data),
    .blink_en  (blink_en),
    .blink_bit (blink_bit),
    .led0      (led0),
    .led1      (led1),
    .led_mux0  (led_mux0),
    .led_mux1  (led_mux1),
    .dp0       (dp0),
    .dp1       (dp1)
  );

  typedef struct {
    logic [19:0] td;
    logic        ben;
    logic [2:0]  bbit;
    int          adv;
    logic [6:0]  l0;
    logic [6:0]  l1;
    logic [3:0]  m;
    logic        d0;
    logic        d1;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [19:0] pack_t(int hh, int hl, int mh, int ml, int sh, int sl);
    return {2'(hh), 4'(hl), 3'(mh), 4'(ml), 3'(sh), 4'(sl)};
  endfunction

  task automatic add(input logic [19:0] td, input logic ben, input logic [2:0] bbit,
                     input int adv, input logic [6:0] l0, input logic [6:0] l1,
                     input logic [3:0] m, input logic d0, input logic d1);
    vec_t v;
    v.td = td; v.ben = ben; v.bbit = bbit; v.adv = adv;
    v.l0 = l0; v.l1 = l1; v.m = m; v.d0 = d0; v.d1 = d1;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [6:0] l0, input logic [6:0] l1,
                       input logic [3:0] m, input logic d0, input logic d1);
    n_tests++;
    if ({led0, led1, led_mux0, led_mux1, dp0, dp1} !== {l0, l1, m, m, d0, d1}) begin
      n_fail++;
      $display("FAIL %s: got led0=%h led1=%h mux0=%b mux1=%b dp0=%b dp1=%b, want led0=%h led1=%h mux0=%b mux1=%b dp0=%b dp1=%b",
               name, led0, led1, led_mux0, led_mux1, dp0, dp1, l0, l1, m, m, d0, d1);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  initial begin
    logic [19:0] t0, t1, t2, t3;
    t0 = 20'h00000;
    t1 = pack_t(1, 2, 3, 4, 5, 6);
    t2 = pack_t(2, 3, 5, 9, 7, 8);
    t3 = pack_t(2, 3, 5, 9, 7, 12);

    rstn = 1'b0; time_data = t0; blink_en = 1'b0; blink_bit = 3'd0;
    repeat (3) @(negedge clk_sys);
    check("reset", 7'h00, 7'h00, 4'b0000, 1'b0, 1'b0);

    // free-running scan of 12:34:56 (one slot = 10 cycles, first 2 dark)
    add(t1, 0, 0,  1, 7'h66, 7'h06, 4'b0000, 0, 0);
    add(t1, 0, 0,  2, 7'h66, 7'h06, 4'b1000, 0, 0);
    add(t1, 0, 0,  8, 7'h40, 7'h5B, 4'b0000, 0, 0);
    add(t1, 0, 0,  2, 7'h40, 7'h5B, 4'b0100, 0, 0);
    add(t1, 0, 0, 10, 7'h6D, 7'h40, 4'b0010, 0, 0);
    // 00:00:00 arrives mid-frame; old digits stay until the frame wrap
    add(t0, 0, 0, 10, 7'h7D, 7'h4F, 4'b0001, 0, 0);
    add(t0, 0, 0,  6, 7'h7D, 7'h4F, 4'b0001, 0, 0);
    add(t0, 0, 0,  1, 7'h7D, 7'h4F, 4'b0001, 0, 0);
    add(t0, 0, 0,  3, 7'h3F, 7'h3F, 4'b1000, 0, 0);
    // 23:59:78 queued, visible from the next frame
    add(t2, 0, 0, 10, 7'h40, 7'h3F, 4'b0100, 0, 0);
    add(t2, 0, 0, 10, 7'h3F, 7'h40, 4'b0010, 0, 0);
    add(t2, 0, 0, 10, 7'h3F, 7'h3F, 4'b0001, 0, 0);
    add(t2, 0, 0, 10, 7'h6F, 7'h5B, 4'b1000, 0, 0);
    add(t2, 0, 0, 10, 7'h40, 7'h4F, 4'b0100, 0, 0);
    add(t2, 0, 0, 10, 7'h07, 7'h40, 4'b0010, 0, 0);
    add(t2, 0, 0, 10, 7'h7F, 7'h6D, 4'b0001, 0, 0);
    // blink min_l, then move to hou_l while the old phase is dark
    add(t2, 1, 2,  8, 7'h6F, 7'h5B, 4'b0000, 0, 0);
    add(t2, 1, 2,  3, 7'h6F, 7'h5B, 4'b1000, 1, 0);
    add(t2, 1, 2,  1, 7'h00, 7'h5B, 4'b1000, 1, 0);
    add(t2, 1, 2,  6, 7'h40, 7'h4F, 4'b0000, 0, 0);
    add(t2, 1, 4,  1, 7'h40, 7'h4F, 4'b0000, 0, 0);
    add(t2, 1, 4,  1, 7'h40, 7'h4F, 4'b0100, 0, 1);
    add(t2, 1, 4, 38, 7'h40, 7'h00, 4'b0000, 0, 0);
    add(t2, 1, 4,  2, 7'h40, 7'h4F, 4'b0100, 0, 1);
    add(t2, 1, 4,  8, 7'h07, 7'h40, 4'b0000, 0, 0);
    // change to hou_h on the same edge the blink counter wraps
    add(t2, 1, 5, 20, 7'h6F, 7'h00, 4'b0000, 0, 0);
    add(t2, 1, 5,  2, 7'h6F, 7'h5B, 4'b1000, 0, 1);
    add(t2, 1, 6,  1, 7'h6F, 7'h5B, 4'b1000, 0, 0);
    // sec_l = C shows the error glyph after the next frame latch
    add(t3, 0, 0, 29, 7'h7F, 7'h6D, 4'b0001, 0, 0);
    add(t3, 0, 0, 40, 7'h79, 7'h6D, 4'b0001, 0, 0);
    add(t3, 0, 0, 32, 7'h07, 7'h40, 4'b0010, 0, 0);

    time_data = t1;
    rstn = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      time_data = vecs[i].td;
      blink_en  = vecs[i].ben;
      blink_bit = vecs[i].bbit;
      step(vecs[i].adv);
      check($sformatf("vec%0d", i), vecs[i].l0, vecs[i].l1, vecs[i].m, vecs[i].d0, vecs[i].d1);
    end

    // reset mid-slot (slot_cnt=5, idx=1): outputs clear without a clock edge
    rstn = 1'b0;
    #1;
    check("async_reset", 7'h00, 7'h00, 4'b0000, 1'b0, 1'b0);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rstn = 1'b1;
    step(1);
    check("restart_guard", 7'h6F, 7'h5B, 4'b0000, 1'b0, 1'b0);
    step(2);
    check("restart_idx3", 7'h6F, 7'h5B, 4'b1000, 1'b0, 1'b0);
    step(10);
    check("restart_idx2", 7'h40, 7'h4F, 4'b0100, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
